// File: rtl/gb_cart_pkg.sv
// Shared types and constants for the GameBoy cartridge to SDRAM bridge.
package gb_cart_pkg;

   localparam int unsigned ADDR_W = 26;
   localparam logic [ADDR_W-1:0] SDRAM_RAM_BASE = 26'h2000000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2
   } bridge_state_e;

   // Eight-bit saturating increment for the Avalon wait counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/gb_rd_cache.sv
// Single-entry read cache: one tag, one data byte, one valid bit.
// A fill always wins over a same-cycle flush so freshly read data survives.
module gb_rd_cache
   import gb_cart_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   output logic [7:0]        rdata,
   input  logic              fill_en,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic [7:0]        fill_data,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_addr,
   input  logic [7:0]        upd_data,
   input  logic              flush
);

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] tag_q, tag_d;
   logic [7:0]        data_q, data_d;

   // Lookup: combinational compare against the stored tag.
   always_comb begin
      hit   = valid_q & (tag_q == lookup_addr);
      rdata = data_q;
   end

   // Next-state: fill, write-through update of a matching tag, flush.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (fill_en) begin
         valid_d = 1'b1;
         tag_d   = fill_addr;
         data_d  = fill_data;
      end else begin
         if (upd_en && (upd_addr == tag_q)) begin
            data_d = upd_data;
         end else begin
            data_d = data_q;
         end
         if (flush) begin
            valid_d = 1'b0;
         end else begin
            valid_d = valid_q;
         end
      end
   end

   // Storage registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         tag_q   <= {ADDR_W{1'b0}};
         data_q  <= 8'h00;
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/gb_cart_sdram_bridge.sv
// Bridge from level-held GameBoy cartridge strobes to single Avalon-MM
// SDRAM accesses, with a one-entry read cache and a GB-clock stall output.
module gb_cart_sdram_bridge
   import gb_cart_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [25:0]       req_addr,
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [7:0]        req_wdata,
   input  logic              flush,
   output logic [7:0]        rsp_rdata,
   output logic              busy,
   output logic              err,
   output logic [25:0]       avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [7:0]        avm_writedata,
   input  logic [7:0]        avm_readdata,
   input  logic              avm_waitrequest
);

   // The wait counter is 8 bits; larger settings are truncated.
   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;

   bridge_state_e     state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [7:0]        rsp_q, rsp_d;
   logic              err_q, err_d;
   logic              avm_read_q, avm_read_d;
   logic              avm_write_q, avm_write_d;
   logic [ADDR_W-1:0] avm_addr_q, avm_addr_d;
   logic [7:0]        avm_wdata_q, avm_wdata_d;

   logic              rd_start, wr_start;
   logic              cache_hit;
   logic [7:0]        cache_rdata;
   logic              fill_en, upd_en;

   gb_rd_cache u_cache (
      .clk         (clk),
      .reset_n     (reset_n),
      .lookup_addr (req_addr),
      .hit         (cache_hit),
      .rdata       (cache_rdata),
      .fill_en     (fill_en),
      .fill_addr   (avm_addr_q),
      .fill_data   (avm_readdata),
      .upd_en      (upd_en),
      .upd_addr    (avm_addr_q),
      .upd_data    (avm_wdata_q),
      .flush       (flush)
   );

   // Edge detection: a read starts on a rising strobe or an address change
   // under a held strobe; a write starts only on the rising strobe.
   always_comb begin
      rd_d     = req_rd;
      wr_d     = req_wr;
      addr_d   = req_addr;
      rd_start = req_rd & (~rd_q | (req_addr != addr_q));
      wr_start = req_wr & ~wr_q;
      busy     = (state_q != IDLE) | wr_start | (rd_start & ~cache_hit);
   end

   // Previous-cycle copies of the GB strobes and address.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_q   <= 1'b0;
         wr_q   <= 1'b0;
         addr_q <= {ADDR_W{1'b0}};
      end else begin
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         addr_q <= addr_d;
      end
   end

   // Transaction FSM next-state: issue, wait, complete or time out.
   // The cache write-update uses the registered write data, which equals
   // req_wdata for the whole strobe.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_d       = rsp_q;
      err_d       = err_q;
      avm_read_d  = avm_read_q;
      avm_write_d = avm_write_q;
      avm_addr_d  = avm_addr_q;
      avm_wdata_d = avm_wdata_q;
      fill_en     = 1'b0;
      upd_en      = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = 8'd0;
            if (wr_start) begin
               state_d     = WRITE;
               avm_write_d = 1'b1;
               avm_addr_d  = req_addr;
               avm_wdata_d = req_wdata;
            end else if (rd_start && cache_hit) begin
               rsp_d = cache_rdata;
            end else if (rd_start) begin
               state_d    = READ;
               avm_read_d = 1'b1;
               avm_addr_d = req_addr;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (!avm_waitrequest) begin
               state_d    = IDLE;
               avm_read_d = 1'b0;
               rsp_d      = avm_readdata;
               fill_en    = 1'b1;
            end else if (cnt_q == TIMEOUT_LIM) begin
               state_d    = IDLE;
               avm_read_d = 1'b0;
               rsp_d      = 8'hFF;
               err_d      = 1'b1;
            end else begin
               cnt_d = sat_inc8(cnt_q);
            end
         end
         WRITE: begin
            if (!avm_waitrequest) begin
               state_d     = IDLE;
               avm_write_d = 1'b0;
               upd_en      = 1'b1;
            end else if (cnt_q == TIMEOUT_LIM) begin
               state_d     = IDLE;
               avm_write_d = 1'b0;
               err_d       = 1'b1;
            end else begin
               cnt_d = sat_inc8(cnt_q);
            end
         end
         default: begin
            state_d     = IDLE;
            avm_read_d  = 1'b0;
            avm_write_d = 1'b0;
         end
      endcase
   end

   // FSM state and registered outputs; reset abandons any transaction.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         rsp_q       <= 8'hFF;
         err_q       <= 1'b0;
         avm_read_q  <= 1'b0;
         avm_write_q <= 1'b0;
         avm_addr_q  <= {ADDR_W{1'b0}};
         avm_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_q       <= rsp_d;
         err_q       <= err_d;
         avm_read_q  <= avm_read_d;
         avm_write_q <= avm_write_d;
         avm_addr_q  <= avm_addr_d;
         avm_wdata_q <= avm_wdata_d;
      end
   end

   assign rsp_rdata     = rsp_q;
   assign err           = err_q;
   assign avm_read      = avm_read_q;
   assign avm_write     = avm_write_q;
   assign avm_address   = avm_addr_q;
   assign avm_writedata = avm_wdata_q;

endmodule
